wb_port_arbiter: RTL

Arbitrates the single register-file write port between the in-order pipeline writeback stage and a long-latency execution unit (multiply/divide) that returns results out of band. It sits after the writeback mux, in front of the register file write port. Pipeline writes always have priority. Long-latency results are buffered in a small FIFO and drained into idle writeback slots. A starvation guard can freeze the pipeline for one cycle to force a drain.

---
 rtl/wb_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write port shared by pipeline writeback and a FIFO of long-latency results; WB_STARVE_GUARD_EN enables the forced-drain starvation guard
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        RegWriteOut,
  output logic [4:0]  RdOut,
  output logic [31:0] WriteDataOut,
  output logic        stall_req,
  output logic        lu_pending
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
`ifdef WB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT) + 1;
  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PEND} state_t;
`endif
  state_t state, state_n;
  logic [4:0] q_rd [DEPTH];
  logic [31:0] q_data [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic slot_idle, empty, full, push, pop, force_drain, we_n;
  logic [4:0] rd_n;
  logic [31:0] data_n;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign slot_idle = !RegWriteW || RdW == 5'd0;
  assign lu_ready = !rst && !full;
  assign push = lu_valid && lu_ready;
  assign lu_pending = state != IDLE;
`ifdef WB_STARVE_GUARD_EN
  logic [WW-1:0] age;
  assign force_drain = state == FORCE;
`else
  assign force_drain = 1'b0;
`endif
  assign stall_req = force_drain;
  assign pop = force_drain || (slot_idle && !empty);
  assign count_n = count + CW'(push) - CW'(pop);
  assign we_n = pop ? q_rd[rptr] != 5'd0 : !slot_idle;
  assign rd_n = pop ? q_rd[rptr] : RdW;
  assign data_n = pop ? q_data[rptr] : ResultW;
  // next state follows occupancy; a starving head with a busy slot forces a one-cycle drain
  always_comb begin
    state_n = count_n != '0 ? PEND : IDLE;
`ifdef WB_STARVE_GUARD_EN
    if (state == PEND && age == WW'(MAX_WAIT - 1) && !slot_idle) state_n = FORCE;
`endif
  end
  // state, FIFO bookkeeping and registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      RegWriteOut <= 1'b0;
      RdOut <= '0;
      WriteDataOut <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      RegWriteOut <= we_n;
      if (we_n) begin
        RdOut <= rd_n;
        WriteDataOut <= data_n;
      end
    end
  end
  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wptr] <= lu_rd;
      q_data[wptr] <= lu_data;
    end
  end
`ifdef WB_STARVE_GUARD_EN
  // age of the FIFO head, cleared by a pop or an empty FIFO, saturating
  always_ff @(posedge clk) begin
    if (rst) age <= '0;
    else age <= (pop || empty) ? '0 : age == WW'(MAX_WAIT - 1) ? age : age + 1'b1;
  end
`endif
endmodule
